bp_io_uc_responder: RTL and testbench

BP_IO_UC_RESPONDER -- requirements
Module: bp_io_uc_responder

---
 rtl/bp_io_uc_responder.sv | 261 ++++++++++++++++++++++++++
 tb/tb_bp_io_uc_responder.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_io_uc_responder.sv
// Uncached I/O responder: one single-beat uncached LCE request becomes a memory forward, then an LCE command.
// Optional memory-response timeout is enabled by defining BP_IO_UC_RESPONDER_TIMEOUT_EN.

package bp_io_uc_responder_pkg;

   typedef enum logic [1:0] {
      e_bp_default_cfg   = 2'd0,
      e_bp_wide_fill_cfg = 2'd1
   } bp_params_e;

   localparam int paddr_width_gp  = 40;
   localparam int lce_id_width_gp = 4;
   localparam int cce_id_width_gp = 4;
   localparam int did_width_gp    = 4;

   function automatic int bedrock_fill_width(bp_params_e cfg);
      case (cfg)
         e_bp_wide_fill_cfg: return 128;
         default:            return 64;
      endcase
   endfunction

   typedef enum logic [3:0] {
      e_bedrock_req_rd_miss = 4'd0,
      e_bedrock_req_wr_miss = 4'd1,
      e_bedrock_req_uc_rd   = 4'd2,
      e_bedrock_req_uc_wr   = 4'd3,
      e_bedrock_req_uc_amo  = 4'd4
   } bp_bedrock_req_type_e;

   typedef enum logic [3:0] {
      e_bedrock_mem_rd  = 4'd0,
      e_bedrock_mem_wr  = 4'd1,
      e_bedrock_mem_amo = 4'd2
   } bp_bedrock_mem_type_e;

   typedef enum logic [3:0] {
      e_bedrock_cmd_sync       = 4'd0,
      e_bedrock_cmd_data       = 4'd4,
      e_bedrock_cmd_uc_data    = 4'd11,
      e_bedrock_cmd_uc_st_done = 4'd12
   } bp_bedrock_cmd_type_e;

   typedef enum logic [3:0] {
      e_bedrock_store  = 4'd0,
      e_bedrock_amoadd = 4'd1
   } bp_bedrock_subop_e;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1   = 3'd0,
      e_bedrock_msg_size_2   = 3'd1,
      e_bedrock_msg_size_4   = 3'd2,
      e_bedrock_msg_size_8   = 3'd3,
      e_bedrock_msg_size_16  = 3'd4,
      e_bedrock_msg_size_32  = 3'd5,
      e_bedrock_msg_size_64  = 3'd6,
      e_bedrock_msg_size_128 = 3'd7
   } bp_bedrock_msg_size_e;

   typedef struct packed {
      logic [did_width_gp-1:0]    src_did;
      logic [lce_id_width_gp-1:0] src_id;
   } bp_bedrock_lce_req_payload_s;

   typedef struct packed {
      bp_bedrock_lce_req_payload_s payload;
      logic [2:0]                  size;
      logic [paddr_width_gp-1:0]   addr;
      logic [3:0]                  subop;
      logic [3:0]                  msg_type;
   } bp_bedrock_lce_req_header_s;

   typedef struct packed {
      logic [did_width_gp-1:0]    src_did;
      logic [lce_id_width_gp-1:0] lce_id;
   } bp_bedrock_mem_payload_s;

   typedef struct packed {
      bp_bedrock_mem_payload_s   payload;
      logic [2:0]                size;
      logic [paddr_width_gp-1:0] addr;
      logic [3:0]                subop;
      logic [3:0]                msg_type;
   } bp_bedrock_mem_header_s;

   typedef struct packed {
      logic [did_width_gp-1:0]    src_did;
      logic [cce_id_width_gp-1:0] src_id;
      logic [lce_id_width_gp-1:0] dst_id;
   } bp_bedrock_lce_cmd_payload_s;

   typedef struct packed {
      bp_bedrock_lce_cmd_payload_s payload;
      logic [2:0]                  size;
      logic [paddr_width_gp-1:0]   addr;
      logic [3:0]                  subop;
      logic [3:0]                  msg_type;
   } bp_bedrock_lce_cmd_header_s;

endpackage

module bp_io_uc_responder
   import bp_io_uc_responder_pkg::*;
#(
   parameter bp_params_e bp_params_p      = e_bp_default_cfg,
   parameter int         timeout_cycles_p = 1024,
   localparam int bedrock_fill_width_p    = bedrock_fill_width(bp_params_p),
   localparam int cce_id_width_p          = cce_id_width_gp,
   localparam int lce_req_header_width_lp = $bits(bp_bedrock_lce_req_header_s),
   localparam int mem_fwd_header_width_lp = $bits(bp_bedrock_mem_header_s),
   localparam int mem_rev_header_width_lp = $bits(bp_bedrock_mem_header_s),
   localparam int lce_cmd_header_width_lp = $bits(bp_bedrock_lce_cmd_header_s)
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic [cce_id_width_p-1:0]          cce_id_i,
   input  logic [lce_req_header_width_lp-1:0] lce_req_header_i,
   input  logic [bedrock_fill_width_p-1:0]    lce_req_data_i,
   input  logic                               lce_req_v_i,
   output logic                               lce_req_ready_and_o,
   output logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_o,
   output logic [bedrock_fill_width_p-1:0]    mem_fwd_data_o,
   output logic                               mem_fwd_v_o,
   input  logic                               mem_fwd_ready_and_i,
   input  logic [mem_rev_header_width_lp-1:0] mem_rev_header_i,
   input  logic [bedrock_fill_width_p-1:0]    mem_rev_data_i,
   input  logic                               mem_rev_v_i,
   output logic                               mem_rev_ready_and_o,
   output logic [lce_cmd_header_width_lp-1:0] lce_cmd_header_o,
   output logic [bedrock_fill_width_p-1:0]    lce_cmd_data_o,
   output logic                               lce_cmd_v_o,
   input  logic                               lce_cmd_ready_and_i,
   output logic                               busy_o,
   output logic                               timeout_o
);

   typedef enum logic [1:0] {e_ready, e_fwd, e_rev, e_cmd} state_e;

   state_e                           r_state;
   bp_bedrock_lce_req_header_s       r_req;
   logic [bedrock_fill_width_p-1:0]  r_req_data;
   logic [bedrock_fill_width_p-1:0]  r_rev_data;

   bp_bedrock_lce_req_header_s       w_in_req;
   bp_bedrock_mem_header_s           w_fwd;
   bp_bedrock_lce_cmd_header_s       w_cmd;
   logic                             w_in_uc;
   logic                             w_is_wr;
   logic                             w_rev_take;
   logic                             w_drain;
   logic                             w_timeout;
   logic                             w_unused;

   assign w_in_req   = lce_req_header_i;
   assign w_in_uc    = (w_in_req.msg_type == e_bedrock_req_uc_rd)
                     | (w_in_req.msg_type == e_bedrock_req_uc_wr);
   assign w_is_wr    = (r_req.msg_type == e_bedrock_req_uc_wr);
   assign w_rev_take = (r_state == e_rev) & mem_rev_v_i & ~w_drain;

`ifdef BP_IO_UC_RESPONDER_TIMEOUT_EN
   localparam int cnt_width_lp = (timeout_cycles_p > 2) ? $clog2(timeout_cycles_p) : 1;

   logic [cnt_width_lp-1:0] r_count;
   logic                    r_drain;

   // The drain flag soaks up the one late beat owed by a timed-out transaction.
   assign w_drain   = r_drain;
   assign w_timeout = (r_state == e_rev) & ~w_rev_take
                    & (r_count == cnt_width_lp'(timeout_cycles_p - 1));
   assign w_unused  = ^{mem_rev_header_i, r_req.subop};
`else
   assign w_drain   = 1'b0;
   assign w_timeout = 1'b0;
   assign w_unused  = ^{mem_rev_header_i, r_req.subop, 1'(timeout_cycles_p)};
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state    <= e_ready;
         r_req      <= '0;
         r_req_data <= '0;
         r_rev_data <= '0;
`ifdef BP_IO_UC_RESPONDER_TIMEOUT_EN
         r_count    <= '0;
         r_drain    <= 1'b0;
`endif
      end else begin
`ifdef BP_IO_UC_RESPONDER_TIMEOUT_EN
         if (r_drain && mem_rev_v_i) r_drain <= 1'b0;
`endif
         case (r_state)
            e_ready: begin
               if (lce_req_v_i) begin
                  r_req      <= w_in_req;
                  r_req_data <= lce_req_data_i;
                  if (w_in_uc) r_state <= e_fwd;
               end
            end
            e_fwd: begin
               if (mem_fwd_ready_and_i) begin
                  r_state <= e_rev;
`ifdef BP_IO_UC_RESPONDER_TIMEOUT_EN
                  r_count <= '0;
`endif
               end
            end
            e_rev: begin
               if (w_rev_take) begin
                  r_rev_data <= mem_rev_data_i;
                  r_state    <= e_cmd;
               end
`ifdef BP_IO_UC_RESPONDER_TIMEOUT_EN
               else if (w_timeout) begin
                  r_rev_data <= '0;
                  r_state    <= e_cmd;
                  r_drain    <= 1'b1;
               end else begin
                  r_count <= r_count + 1'b1;
               end
`endif
            end
            e_cmd: begin
               if (lce_cmd_ready_and_i) r_state <= e_ready;
            end
            default: r_state <= e_ready;
         endcase
      end
   end

   // Outgoing headers are pure functions of the registered request, so they stay stable under backpressure.
   always_comb begin
      w_fwd                 = '0;
      w_fwd.msg_type        = w_is_wr ? e_bedrock_mem_wr : e_bedrock_mem_rd;
      w_fwd.subop           = e_bedrock_store;
      w_fwd.addr            = r_req.addr;
      w_fwd.size            = r_req.size;
      w_fwd.payload.lce_id  = r_req.payload.src_id;
      w_fwd.payload.src_did = r_req.payload.src_did;

      w_cmd                 = '0;
      w_cmd.msg_type        = w_is_wr ? e_bedrock_cmd_uc_st_done : e_bedrock_cmd_uc_data;
      w_cmd.addr            = r_req.addr;
      w_cmd.size            = r_req.size;
      w_cmd.payload.dst_id  = r_req.payload.src_id;
      w_cmd.payload.src_id  = cce_id_i;
      w_cmd.payload.src_did = r_req.payload.src_did;
   end

   assign lce_req_ready_and_o = (r_state == e_ready) & ~reset_i;
   assign mem_fwd_v_o         = (r_state == e_fwd) & ~reset_i;
   assign mem_rev_ready_and_o = ((r_state == e_rev) | w_drain) & ~reset_i;
   assign lce_cmd_v_o         = (r_state == e_cmd) & ~reset_i;
   assign busy_o              = (r_state != e_ready) & ~reset_i;
   assign timeout_o           = w_timeout & ~reset_i;

   assign mem_fwd_header_o    = w_fwd;
   assign mem_fwd_data_o      = r_req_data;
   assign lce_cmd_header_o    = w_cmd;
   assign lce_cmd_data_o      = w_is_wr ? '0 : r_rev_data;

endmodule

// File: tb/tb_bp_io_uc_responder.sv
// Directed self-checking bench for bp_io_uc_responder; the timeout scenario runs when BP_IO_UC_RESPONDER_TIMEOUT_EN is defined.

module tb_bp_io_uc_responder;
   import bp_io_uc_responder_pkg::*;

   localparam int fillW = bedrock_fill_width(e_bp_default_cfg);
   localparam logic [cce_id_width_gp-1:0] cceId = 4'h3;

   logic                       clk_i = 1'b0;
   logic                       reset_i;
   logic [cce_id_width_gp-1:0] cce_id_i;
   bp_bedrock_lce_req_header_s lce_req_header_i;
   logic [fillW-1:0]           lce_req_data_i;
   logic                       lce_req_v_i;
   logic                       lce_req_ready_and_o;
   bp_bedrock_mem_header_s     mem_fwd_header_o;
   logic [fillW-1:0]           mem_fwd_data_o;
   logic                       mem_fwd_v_o;
   logic                       mem_fwd_ready_and_i;
   bp_bedrock_mem_header_s     mem_rev_header_i;
   logic [fillW-1:0]           mem_rev_data_i;
   logic                       mem_rev_v_i;
   logic                       mem_rev_ready_and_o;
   bp_bedrock_lce_cmd_header_s lce_cmd_header_o;
   logic [fillW-1:0]           lce_cmd_data_o;
   logic                       lce_cmd_v_o;
   logic                       lce_cmd_ready_and_i;
   logic                       busy_o;
   logic                       timeout_o;

   int nTests  = 0;
   int nFailed = 0;

   // {req_ready, fwd_v, rev_ready, cmd_v, busy, timeout}
   logic [5:0] st;
   assign st = {lce_req_ready_and_o, mem_fwd_v_o, mem_rev_ready_and_o, lce_cmd_v_o, busy_o, timeout_o};

   bp_io_uc_responder #(
      .bp_params_p      (e_bp_default_cfg),
      .timeout_cycles_p (16)
   ) dut (
      .clk_i               (clk_i),
      .reset_i             (reset_i),
      .cce_id_i            (cce_id_i),
      .lce_req_header_i    (lce_req_header_i),
      .lce_req_data_i      (lce_req_data_i),
      .lce_req_v_i         (lce_req_v_i),
      .lce_req_ready_and_o (lce_req_ready_and_o),
      .mem_fwd_header_o    (mem_fwd_header_o),
      .mem_fwd_data_o      (mem_fwd_data_o),
      .mem_fwd_v_o         (mem_fwd_v_o),
      .mem_fwd_ready_and_i (mem_fwd_ready_and_i),
      .mem_rev_header_i    (mem_rev_header_i),
      .mem_rev_data_i      (mem_rev_data_i),
      .mem_rev_v_i         (mem_rev_v_i),
      .mem_rev_ready_and_o (mem_rev_ready_and_o),
      .lce_cmd_header_o    (lce_cmd_header_o),
      .lce_cmd_data_o      (lce_cmd_data_o),
      .lce_cmd_v_o         (lce_cmd_v_o),
      .lce_cmd_ready_and_i (lce_cmd_ready_and_i),
      .busy_o              (busy_o),
      .timeout_o           (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic bp_bedrock_lce_req_header_s makeReq(logic [3:0] t, logic [39:0] a, logic [2:0] s,
                                                           logic [3:0] id, logic [3:0] did);
      bp_bedrock_lce_req_header_s h = '0;
      h.msg_type = t; h.addr = a; h.size = s; h.payload.src_id = id; h.payload.src_did = did;
      return h;
   endfunction

   function automatic bp_bedrock_mem_header_s expFwd(logic [3:0] t, logic [39:0] a, logic [2:0] s,
                                                      logic [3:0] id, logic [3:0] did);
      bp_bedrock_mem_header_s h = '0;
      h.msg_type = t; h.addr = a; h.size = s; h.payload.lce_id = id; h.payload.src_did = did;
      return h;
   endfunction

   function automatic bp_bedrock_lce_cmd_header_s expCmd(logic [3:0] t, logic [39:0] a, logic [2:0] s,
                                                          logic [3:0] id, logic [3:0] did);
      bp_bedrock_lce_cmd_header_s h = '0;
      h.msg_type = t; h.addr = a; h.size = s;
      h.payload.dst_id = id; h.payload.src_id = cceId; h.payload.src_did = did;
      return h;
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Presents one request for a single cycle; caller must be in the ready state.
   task automatic applyStimulus(input bp_bedrock_lce_req_header_s h, input logic [fillW-1:0] d);
      lce_req_header_i = h;
      lce_req_data_i   = d;
      lce_req_v_i      = 1'b1;
      step();
      lce_req_v_i      = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      step();
      step();
      nTests++;
      if (st !== 6'b000000) begin nFailed++; $display("[TB] FAIL reset_status got %b want %b", st, 6'b000000); end
      reset_i = 1'b0;
      #1;
      nTests++;
      if (st !== 6'b100000) begin nFailed++; $display("[TB] FAIL post_reset_status got %b want %b", st, 6'b100000); end
      nTests++;
      if (mem_fwd_header_o !== '0 || mem_fwd_data_o !== '0) begin
         nFailed++; $display("[TB] FAIL reset_regs_clear got %h/%h want 0/0", mem_fwd_header_o, mem_fwd_data_o);
      end
      step();
   endtask

   task automatic test_uc_read();
      bp_bedrock_mem_header_s     eF;
      bp_bedrock_lce_cmd_header_s eC;
      eF = expFwd(e_bedrock_mem_rd, 40'h80_0000_0010, e_bedrock_msg_size_8, 4'd1, 4'd2);
      eC = expCmd(e_bedrock_cmd_uc_data, 40'h80_0000_0010, e_bedrock_msg_size_8, 4'd1, 4'd2);
      mem_fwd_ready_and_i = 1'b1;
      lce_cmd_ready_and_i = 1'b1;
      applyStimulus(makeReq(e_bedrock_req_uc_rd, 40'h80_0000_0010, e_bedrock_msg_size_8, 4'd1, 4'd2), '0);
      nTests++;
      if (st !== 6'b010010) begin nFailed++; $display("[TB] FAIL rd_fwd_status got %b want %b", st, 6'b010010); end
      nTests++;
      if (mem_fwd_header_o !== eF) begin nFailed++; $display("[TB] FAIL rd_fwd_header got %h want %h", mem_fwd_header_o, eF); end
      step();
      nTests++;
      if (st !== 6'b001010) begin nFailed++; $display("[TB] FAIL rd_rev_status got %b want %b", st, 6'b001010); end
      mem_rev_header_i = '1;
      mem_rev_data_i   = 64'hDEAD_BEEF;
      mem_rev_v_i      = 1'b1;
      step();
      mem_rev_v_i = 1'b0;
      nTests++;
      if (st !== 6'b000110) begin nFailed++; $display("[TB] FAIL rd_cmd_status got %b want %b", st, 6'b000110); end
      nTests++;
      if (lce_cmd_header_o !== eC) begin nFailed++; $display("[TB] FAIL rd_cmd_header got %h want %h", lce_cmd_header_o, eC); end
      nTests++;
      if (lce_cmd_data_o !== 64'hDEAD_BEEF) begin
         nFailed++; $display("[TB] FAIL rd_cmd_data got %h want %h", lce_cmd_data_o, 64'hDEAD_BEEF);
      end
      step();
      nTests++;
      if (st !== 6'b100000) begin nFailed++; $display("[TB] FAIL rd_done_status got %b want %b", st, 6'b100000); end
   endtask

   task automatic test_uc_write_stall();
      bp_bedrock_mem_header_s     eF;
      bp_bedrock_lce_cmd_header_s eC;
      eF = expFwd(e_bedrock_mem_wr, 40'h80_0000_0100, e_bedrock_msg_size_4, 4'd2, 4'd5);
      eC = expCmd(e_bedrock_cmd_uc_st_done, 40'h80_0000_0100, e_bedrock_msg_size_4, 4'd2, 4'd5);
      mem_fwd_ready_and_i = 1'b0;
      applyStimulus(makeReq(e_bedrock_req_uc_wr, 40'h80_0000_0100, e_bedrock_msg_size_4, 4'd2, 4'd5), 64'h1234);
      for (int i = 0; i < 5; i++) begin
         nTests++;
         if (st !== 6'b010010) begin nFailed++; $display("[TB] FAIL wr_stall_status[%0d] got %b want %b", i, st, 6'b010010); end
         nTests++;
         if (mem_fwd_header_o !== eF) begin
            nFailed++; $display("[TB] FAIL wr_stall_header[%0d] got %h want %h", i, mem_fwd_header_o, eF);
         end
         nTests++;
         if (mem_fwd_data_o !== 64'h1234) begin
            nFailed++; $display("[TB] FAIL wr_stall_data[%0d] got %h want %h", i, mem_fwd_data_o, 64'h1234);
         end
         if (i == 4) mem_fwd_ready_and_i = 1'b1;
         step();
      end
      nTests++;
      if (st !== 6'b001010) begin nFailed++; $display("[TB] FAIL wr_rev_status got %b want %b", st, 6'b001010); end
      mem_rev_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
      mem_rev_v_i    = 1'b1;
      step();
      mem_rev_v_i = 1'b0;
      nTests++;
      if (lce_cmd_header_o !== eC) begin nFailed++; $display("[TB] FAIL wr_cmd_header got %h want %h", lce_cmd_header_o, eC); end
      nTests++;
      if (lce_cmd_data_o !== '0) begin nFailed++; $display("[TB] FAIL wr_cmd_data got %h want 0", lce_cmd_data_o); end
      step();
      nTests++;
      if (st !== 6'b100000) begin nFailed++; $display("[TB] FAIL wr_done_status got %b want %b", st, 6'b100000); end
   endtask

   task automatic test_cmd_stall();
      bp_bedrock_lce_cmd_header_s eC;
      eC = expCmd(e_bedrock_cmd_uc_data, 40'h80_0000_0040, e_bedrock_msg_size_8, 4'd3, 4'd1);
      lce_cmd_ready_and_i = 1'b0;
      applyStimulus(makeReq(e_bedrock_req_uc_rd, 40'h80_0000_0040, e_bedrock_msg_size_8, 4'd3, 4'd1), '0);
      step();
      mem_rev_data_i = 64'h0123_4567_89AB_CDEF;
      mem_rev_v_i    = 1'b1;
      step();
      mem_rev_v_i = 1'b0;
      // A competing request is offered throughout the stall and must not be taken.
      lce_req_header_i = makeReq(e_bedrock_req_uc_wr, 40'h00_0000_0ABC, e_bedrock_msg_size_1, 4'd7, 4'd7);
      lce_req_v_i      = 1'b1;
      for (int i = 0; i < 10; i++) begin
         nTests++;
         if (st !== 6'b000110) begin nFailed++; $display("[TB] FAIL cmd_stall_status[%0d] got %b want %b", i, st, 6'b000110); end
         nTests++;
         if (lce_cmd_header_o !== eC || lce_cmd_data_o !== 64'h0123_4567_89AB_CDEF) begin
            nFailed++; $display("[TB] FAIL cmd_stall_hold[%0d] got %h/%h want %h/%h", i, lce_cmd_header_o, lce_cmd_data_o,
                                eC, 64'h0123_4567_89AB_CDEF);
         end
         if (i == 9) begin
            lce_cmd_ready_and_i = 1'b1;
            lce_req_v_i         = 1'b0;
         end
         step();
      end
      nTests++;
      if (st !== 6'b100000) begin nFailed++; $display("[TB] FAIL cmd_stall_done got %b want %b", st, 6'b100000); end
   endtask

   task automatic test_back_to_back();
      bp_bedrock_mem_header_s eF;
      eF = expFwd(e_bedrock_mem_wr, 40'h80_0000_0200, e_bedrock_msg_size_2, 4'd4, 4'd6);
      mem_fwd_ready_and_i = 1'b1;
      lce_cmd_ready_and_i = 1'b1;
      applyStimulus(makeReq(e_bedrock_req_rd_miss, 40'h80_0000_0300, e_bedrock_msg_size_8, 4'd1, 4'd1), '0);
      nTests++;
      if (st !== 6'b100000) begin nFailed++; $display("[TB] FAIL discard_status got %b want %b", st, 6'b100000); end
      applyStimulus(makeReq(e_bedrock_req_uc_rd, 40'h80_0000_0400, e_bedrock_msg_size_8, 4'd2, 4'd3), '0);
      nTests++;
      if (st !== 6'b010010) begin nFailed++; $display("[TB] FAIL b2b_fwd_status got %b want %b", st, 6'b010010); end
      step();
      mem_rev_data_i = 64'h77;
      mem_rev_v_i    = 1'b1;
      step();
      mem_rev_v_i = 1'b0;
      nTests++;
      if (lce_cmd_data_o !== 64'h77) begin nFailed++; $display("[TB] FAIL b2b_cmd_data got %h want %h", lce_cmd_data_o, 64'h77); end
      lce_req_header_i = makeReq(e_bedrock_req_uc_wr, 40'h80_0000_0200, e_bedrock_msg_size_2, 4'd4, 4'd6);
      lce_req_data_i   = 64'h55AA;
      lce_req_v_i      = 1'b1;
      step();
      nTests++;
      if (st !== 6'b100000) begin nFailed++; $display("[TB] FAIL b2b_ready_status got %b want %b", st, 6'b100000); end
      step();
      lce_req_v_i = 1'b0;
      nTests++;
      if (st !== 6'b010010 || mem_fwd_header_o !== eF || mem_fwd_data_o !== 64'h55AA) begin
         nFailed++; $display("[TB] FAIL b2b_next_fwd got %b/%h/%h want %b/%h/%h", st, mem_fwd_header_o, mem_fwd_data_o,
                             6'b010010, eF, 64'h55AA);
      end
      step();
      mem_rev_v_i = 1'b1;
      step();
      mem_rev_v_i = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      applyStimulus(makeReq(e_bedrock_req_uc_rd, 40'h80_0000_0500, e_bedrock_msg_size_8, 4'd1, 4'd2), 64'h99);
      step();
      nTests++;
      if (st !== 6'b001010) begin nFailed++; $display("[TB] FAIL mid_rev_status got %b want %b", st, 6'b001010); end
      reset_i        = 1'b1;
      mem_rev_data_i = 64'h66;
      mem_rev_v_i    = 1'b1;
      step();
      nTests++;
      if (st !== 6'b000000) begin nFailed++; $display("[TB] FAIL mid_reset_status got %b want %b", st, 6'b000000); end
      reset_i = 1'b0;
      step();
      nTests++;
      if (st !== 6'b100000) begin nFailed++; $display("[TB] FAIL mid_after_status got %b want %b", st, 6'b100000); end
      nTests++;
      if (mem_fwd_header_o !== '0 || mem_fwd_data_o !== '0) begin
         nFailed++; $display("[TB] FAIL mid_regs_clear got %h/%h want 0/0", mem_fwd_header_o, mem_fwd_data_o);
      end
      mem_rev_v_i = 1'b0;
   endtask

`ifdef BP_IO_UC_RESPONDER_TIMEOUT_EN
   task automatic test_timeout();
      bp_bedrock_lce_cmd_header_s eC;
      eC = expCmd(e_bedrock_cmd_uc_data, 40'h80_0000_0080, e_bedrock_msg_size_8, 4'd1, 4'd2);
      mem_fwd_ready_and_i = 1'b1;
      lce_cmd_ready_and_i = 1'b1;
      applyStimulus(makeReq(e_bedrock_req_uc_rd, 40'h80_0000_0080, e_bedrock_msg_size_8, 4'd1, 4'd2), '0);
      step();
      for (int i = 1; i <= 16; i++) begin
         nTests++;
         if (st !== ((i == 16) ? 6'b001011 : 6'b001010)) begin
            nFailed++; $display("[TB] FAIL to_wait_status[%0d] got %b want %b", i, st, (i == 16) ? 6'b001011 : 6'b001010);
         end
         step();
      end
      nTests++;
      if (st !== 6'b001110) begin nFailed++; $display("[TB] FAIL to_cmd_status got %b want %b", st, 6'b001110); end
      nTests++;
      if (lce_cmd_header_o !== eC || lce_cmd_data_o !== '0) begin
         nFailed++; $display("[TB] FAIL to_cmd got %h/%h want %h/0", lce_cmd_header_o, lce_cmd_data_o, eC);
      end
      step();
      nTests++;
      if (st !== 6'b101000) begin nFailed++; $display("[TB] FAIL to_drain_status got %b want %b", st, 6'b101000); end
      mem_rev_data_i = 64'hBAD;
      mem_rev_v_i    = 1'b1;
      step();
      mem_rev_v_i = 1'b0;
      nTests++;
      if (st !== 6'b100000) begin nFailed++; $display("[TB] FAIL to_drained_status got %b want %b", st, 6'b100000); end
      applyStimulus(makeReq(e_bedrock_req_uc_rd, 40'h80_0000_0088, e_bedrock_msg_size_8, 4'd1, 4'd2), '0);
      step();
      mem_rev_data_i = 64'h5555;
      mem_rev_v_i    = 1'b1;
      step();
      mem_rev_v_i = 1'b0;
      nTests++;
      if (st !== 6'b000110 || lce_cmd_data_o !== 64'h5555) begin
         nFailed++; $display("[TB] FAIL to_recover got %b/%h want %b/%h", st, lce_cmd_data_o, 6'b000110, 64'h5555);
      end
      step();
   endtask
`else
   task automatic test_no_timeout();
      mem_fwd_ready_and_i = 1'b1;
      lce_cmd_ready_and_i = 1'b1;
      applyStimulus(makeReq(e_bedrock_req_uc_rd, 40'h80_0000_0080, e_bedrock_msg_size_8, 4'd1, 4'd2), '0);
      step();
      for (int i = 0; i < 40; i++) begin
         nTests++;
         if (st !== 6'b001010) begin nFailed++; $display("[TB] FAIL wait_status[%0d] got %b want %b", i, st, 6'b001010); end
         step();
      end
      mem_rev_data_i = 64'h5555;
      mem_rev_v_i    = 1'b1;
      step();
      mem_rev_v_i = 1'b0;
      nTests++;
      if (st !== 6'b000110 || lce_cmd_data_o !== 64'h5555) begin
         nFailed++; $display("[TB] FAIL wait_cmd got %b/%h want %b/%h", st, lce_cmd_data_o, 6'b000110, 64'h5555);
      end
      step();
   endtask
`endif

   initial begin
      reset_i             = 1'b1;
      cce_id_i            = cceId;
      lce_req_header_i    = '0;
      lce_req_data_i      = '0;
      lce_req_v_i         = 1'b0;
      mem_fwd_ready_and_i = 1'b1;
      mem_rev_header_i    = '0;
      mem_rev_data_i      = '0;
      mem_rev_v_i         = 1'b0;
      lce_cmd_ready_and_i = 1'b1;
      test_reset();
      test_uc_read();
      test_uc_write_stall();
      test_cmd_stall();
      test_back_to_back();
      test_reset_mid();
`ifdef BP_IO_UC_RESPONDER_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", nTests, nFailed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

endmodule
